// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register sequencer: opcodes, FSM states and step-count helpers.
package reg_seq_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    OP_CLEAR = 3'd0,
    OP_LOAD  = 3'd1,
    OP_INC   = 3'd2,
    OP_DEC   = 3'd3,
    OP_SHR   = 3'd4,
    OP_SHL   = 3'd5,
    OP_ROTR  = 3'd6,
    OP_ROTL  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // CLEAR and LOAD are single-shot; everything else repeats cmd_amt times.
  function automatic logic [CNT_W-1:0] step_count(input op_e op, input logic [CNT_W-1:0] amt);
    if (op == OP_CLEAR || op == OP_LOAD) step_count = CNT_W'(1);
    else                                 step_count = amt;
  endfunction

endpackage

// File: rtl/register_sequencer_register.sv
// Strobe-driven datapath register with clear, load, inc/dec and one-bit shifts.
module register_sequencer_register #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cl_i,
  input  logic                  ld_i,
  input  logic                  inc_i,
  input  logic                  dec_i,
  input  logic                  sr_i,
  input  logic                  ir_i,
  input  logic                  sl_i,
  input  logic                  il_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] value_q;

  // ir/il are the fill bits entering at the MSB/LSB for right/left shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     value_q <= '0;
    else if (cl_i)  value_q <= '0;
    else if (ld_i)  value_q <= d_i;
    else if (inc_i) value_q <= value_q + DATA_WIDTH'(1);
    else if (dec_i) value_q <= value_q - DATA_WIDTH'(1);
    else if (sr_i)  value_q <= {ir_i, value_q[DATA_WIDTH-1:1]};
    else if (sl_i)  value_q <= {value_q[DATA_WIDTH-2:0], il_i};
  end

  assign q_o = value_q;

endmodule

// File: rtl/register_sequencer.sv
// Command sequencer: latches one opcode and repeats its strobe on the datapath register.
module register_sequencer
  import reg_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [CNT_W-1:0]      cmd_amt,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  serial_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] out
);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  cl, ld, inc, dec, sr, ir, sl, il;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_CLEAR;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Only the latched op drives strobes, so cmd_* may change freely once accepted.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    cl = 1'b0; ld = 1'b0; inc = 1'b0; dec = 1'b0;
    sr = 1'b0; ir = 1'b0; sl = 1'b0; il = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          data_d  = cmd_data;
          cnt_d   = step_count(op_e'(cmd_op), cmd_amt);
          state_d = (cnt_d == '0) ? ST_DONE : ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        case (op_q)
          OP_CLEAR: cl = 1'b1;
          OP_LOAD:  ld = 1'b1;
          OP_INC:   inc = 1'b1;
          OP_DEC:   dec = 1'b1;
          OP_SHR:   begin sr = 1'b1; ir = serial_in;         end
          OP_ROTR:  begin sr = 1'b1; ir = out[0];            end
          OP_SHL:   begin sl = 1'b1; il = serial_in;         end
          OP_ROTL:  begin sl = 1'b1; il = out[DATA_WIDTH-1]; end
        endcase
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_EXEC);
  assign done      = (state_q == ST_DONE);

  register_sequencer_register #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_register (
    .clk   (clk),
    .rst_n (rst_n),
    .cl_i  (cl),
    .ld_i  (ld),
    .inc_i (inc),
    .dec_i (dec),
    .sr_i  (sr),
    .ir_i  (ir),
    .sl_i  (sl),
    .il_i  (il),
    .d_i   (data_q),
    .q_o   (out)
  );

endmodule

// File: doc/register_sequencer.md
REGISTER_SEQUENCER -- requirements
Module: register_sequencer

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16, giving the width of the datapath register and of cmd_data/out.
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
REQ-003 The module SHALL have the following ports.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  opcode: 0 CLEAR, 1 LOAD, 2 INC, 3 DEC, 4 SHR, 5 SHL, 6 ROTR, 7 ROTL.
- cmd_amt  input  4  repeat/shift count, 0..15.
- cmd_data  input  DATA_WIDTH  LOAD operand.
- serial_in  input  1  fill bit for SHR/SHL.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.
- out  output  DATA_WIDTH  current register contents.

Function
REQ-004 The sequencer SHALL own one DATA_WIDTH register with strobes cl, ld, inc, dec, sr, ir, sl and il, with priority cl > ld > inc > dec > sr > sl, and SHALL assert at most one strobe per cycle.
REQ-005 The FSM SHALL have states IDLE, EXEC and DONE; cmd_ready = (state==IDLE), busy = (state==EXEC), done = (state==DONE).
REQ-006 A command SHALL be accepted on a rising edge where cmd_valid && cmd_ready; op, amt and data SHALL be latched at that edge and ignored afterwards.
REQ-007 On acceptance, CLEAR and LOAD SHALL set the step count to 1; all other opcodes SHALL set the step count to cmd_amt.
REQ-008 On acceptance with a step count of 0, the FSM SHALL go directly to DONE and out SHALL be unchanged.
REQ-009 In EXEC, each cycle SHALL assert the strobe for the latched op, update the register at the next edge and decrement the remaining count; after the last step the FSM SHALL go to DONE.
REQ-010 The step count N SHALL set latency: acceptance edge, then N EXEC cycles, then one DONE cycle; cmd_ready SHALL return high on the cycle after DONE.
REQ-011 DONE SHALL always return to IDLE after one cycle.
REQ-012 INC and DEC SHALL wrap modulo 2^DATA_WIDTH (0xFFFF+1 = 0x0000, 0x0000-1 = 0xFFFF).
REQ-013 SHR SHALL insert serial_in into the MSB and SHL into the LSB, with serial_in sampled in each step cycle.
REQ-014 ROTR SHALL drive ir = out[0] and ROTL SHALL drive il = out[DATA_WIDTH-1], each taken from the current register value.
REQ-015 cmd_valid asserted while busy or done SHALL be ignored without loss of the in-flight command; the requester SHALL hold it until accepted.
REQ-016 out SHALL reflect the register directly, with no extra pipeline stage.

Reset
REQ-017 While rst_n is low the module SHALL be in IDLE with out = 0, busy = 0, done = 0 and cmd_ready = 1, and all latched command fields and the step count SHALL be 0.
REQ-018 Reset asserted mid-command SHALL abort it immediately: no done pulse, out = 0 and the FSM in IDLE.

Structure
REQ-019 Opcode constants, FSM state encodings and the count width (4) SHALL reside in a shared package/include file, reg_seq_pkg.
REQ-020 The datapath register SHALL be a single sub-module instance, register, driven only by the sequencer's strobes; the FSM and counter SHALL stay in register_sequencer.

Verification
REQ-021 The bench SHALL cover LOAD: LOAD 0xA5C3 -> out = 0xA5C3 one edge after EXEC, done pulses once, cmd_ready high 3 cycles after acceptance.
REQ-022 The bench SHALL cover ROTL wrap: LOAD 0x8001 then ROTL amt=4 -> busy for exactly 4 cycles, final out = 0x0018.
REQ-023 The bench SHALL cover INC/DEC wrap: LOAD 0xFFFE, INC amt=3 -> 0x0001; then DEC amt=2 -> 0xFFFF.
REQ-024 The bench SHALL cover serial fill and zero count: SHR amt=4 with serial_in=1 from 0x0000 -> 0xF000; SHL amt=0 -> done on the next cycle, out unchanged.
REQ-025 The bench SHALL cover back-pressure: cmd_valid held high with a second op during EXEC -> second op accepted only in IDLE, first op's result intact.
REQ-026 The bench SHALL cover reset mid-op: rst_n low during SHL amt=8 at step 3 -> out = 0, no done pulse, cmd_ready = 1 after release.
